operand_fetch_stage: RTL

//  Decode/operand-fetch pipeline stage directly upstream of the 16-entry register file.
//  - Splits an incoming instruction into fields and drives the register file read addresses.
//  - Bypasses same-cycle writeback data, tracks pending writes with a 16-bit scoreboard,

---
 rtl/operand_fetch_stage_pkg.sv | 32 +++
 rtl/operand_fetch_stage_scoreboard.sv | 36 +++
 rtl/operand_fetch_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// Shared definitions for the operand-fetch stage: opcode classes, instruction
// field positions and the per-opcode read/write classification helpers.
package operand_fetch_stage_pkg;

    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_BRANCH = 4'hD;
    localparam logic [3:0] OP_LOADI  = 4'hE;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // R-type and BRANCH read both sources; NOP and LOADI read none.
    function automatic logic uses_rs(input logic [3:0] op);
        return (op != OP_NOP) && (op != OP_LOADI);
    endfunction

    function automatic logic writes_rd(input logic [3:0] op);
        return (op != OP_NOP) && (op != OP_BRANCH);
    endfunction

endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue of a writer,
// cleared on writeback; a set and clear to the same index leaves the bit set.
module operand_fetch_stage_scoreboard
    import operand_fetch_stage_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_set_en,
    input  logic [REG_IDX_W-1:0] i_set_idx,
    input  logic                 i_clr_en,
    input  logic [REG_IDX_W-1:0] i_clr_idx,
    output logic [NUM_REGS-1:0]  o_pend
);

    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en) w_set_mask[i_set_idx] = 1'b1;
        if (i_clr_en) w_clr_mask[i_clr_idx] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand-fetch stage: drives register file read addresses, bypasses
// same-cycle writeback, stalls on RAW/WAW hazards and registers operands.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset_asynchronous,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [15:0]  i_in_instr,
    output logic [3:0]   o_rf_read_address0,
    output logic [3:0]   o_rf_read_address1,
    input  logic [W-1:0] i_rf_read_data0,
    input  logic [W-1:0] i_rf_read_data1,
    input  logic         i_wb_enable,
    input  logic [3:0]   i_wb_address,
    input  logic [W-1:0] i_wb_data,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [3:0]   o_out_opcode,
    output logic [3:0]   o_out_rd,
    output logic         o_out_writes_rd,
    output logic [W-1:0] o_out_operand_a,
    output logic [W-1:0] o_out_operand_b
);

    logic [3:0]          w_op;
    logic [3:0]          w_rd;
    logic [3:0]          w_rs1;
    logic [3:0]          w_rs2;
    logic [7:0]          w_imm8;
    logic                w_uses;
    logic                w_writes;
    logic                w_fwd0;
    logic                w_fwd1;
    logic                w_wb_rd;
    logic [W-1:0]        w_src_a;
    logic [W-1:0]        w_src_b;
    logic [W-1:0]        w_operand_a;
    logic [W-1:0]        w_operand_b;
    logic [NUM_REGS-1:0] w_pend;
    logic                w_raw;
    logic                w_waw;
    logic                w_stall;
    logic                w_issue;

    logic                r_out_valid;
    logic [3:0]          r_out_opcode;
    logic [3:0]          r_out_rd;
    logic                r_out_writes_rd;
    logic [W-1:0]        r_out_operand_a;
    logic [W-1:0]        r_out_operand_b;

    assign w_op   = i_in_instr[OPC_MSB:OPC_LSB];
    assign w_rd   = i_in_instr[RD_MSB:RD_LSB];
    assign w_rs1  = i_in_instr[RS1_MSB:RS1_LSB];
    assign w_rs2  = i_in_instr[RS2_MSB:RS2_LSB];
    assign w_imm8 = i_in_instr[IMM_MSB:IMM_LSB];

    assign w_uses   = uses_rs(w_op);
    assign w_writes = writes_rd(w_op);

    assign o_rf_read_address0 = w_rs1;
    assign o_rf_read_address1 = w_rs2;

    // Writeback in flight this cycle is newer than what the register file returns.
    assign w_fwd0  = i_wb_enable && (i_wb_address == w_rs1);
    assign w_fwd1  = i_wb_enable && (i_wb_address == w_rs2);
    assign w_wb_rd = i_wb_enable && (i_wb_address == w_rd);

    assign w_src_a = w_fwd0 ? i_wb_data : i_rf_read_data0;
    assign w_src_b = w_fwd1 ? i_wb_data : i_rf_read_data1;

    always_comb begin
        w_operand_a = '0;
        w_operand_b = '0;
        if (w_op == OP_LOADI) begin
            w_operand_b = W'(w_imm8);
        end else if (w_uses) begin
            w_operand_a = w_src_a;
            w_operand_b = w_src_b;
        end
    end

    assign w_raw   = w_uses && ((w_pend[w_rs1] && !w_fwd0) || (w_pend[w_rs2] && !w_fwd1));
    assign w_waw   = w_writes && w_pend[w_rd] && !w_wb_rd;
    assign w_stall = w_raw || w_waw;

    assign o_in_ready = !w_stall && (!r_out_valid || i_out_ready);
    assign w_issue    = i_in_valid && o_in_ready;

    operand_fetch_stage_scoreboard u_sb (
        .i_clk     (i_clk),
        .i_rst     (i_reset_asynchronous),
        .i_set_en  (w_issue && w_writes),
        .i_set_idx (w_rd),
        .i_clr_en  (i_wb_enable),
        .i_clr_idx (i_wb_address),
        .o_pend    (w_pend)
    );

    always_ff @(posedge i_clk or posedge i_reset_asynchronous) begin
        if (i_reset_asynchronous) begin
            r_out_valid     <= 1'b0;
            r_out_opcode    <= '0;
            r_out_rd        <= '0;
            r_out_writes_rd <= 1'b0;
            r_out_operand_a <= '0;
            r_out_operand_b <= '0;
        end else if (w_issue) begin
            r_out_valid     <= 1'b1;
            r_out_opcode    <= w_op;
            r_out_rd        <= w_rd;
            r_out_writes_rd <= w_writes;
            r_out_operand_a <= w_operand_a;
            r_out_operand_b <= w_operand_b;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid     = r_out_valid;
    assign o_out_opcode    = r_out_opcode;
    assign o_out_rd        = r_out_rd;
    assign o_out_writes_rd = r_out_writes_rd;
    assign o_out_operand_a = r_out_operand_a;
    assign o_out_operand_b = r_out_operand_b;

endmodule
